// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, field offsets,
// CSR sideband layout and exception codes.
package mem_stage_pkg;

  localparam int EXE_TO_MEM_BUS_WD = 78;
  localparam int MEM_TO_WB_BUS_WD  = 70;
  localparam int CSR_BUS_WD        = 113;

  // Execute-to-memory bus field positions
  localparam int BUS_PC_LSB     = 0;
  localparam int BUS_ALU_LSB    = 32;
  localparam int BUS_DEST_LSB   = 64;
  localparam int BUS_GR_WE      = 69;
  localparam int BUS_LOAD_OP    = 70;
  localparam int BUS_LU12I_W    = 71;
  localparam int BUS_SIGNED_OPT = 72;
  localparam int BUS_LDTYPE_LSB = 73;

  // CSR/exception sideband field positions. The named fields occupy the low
  // 102 bits; bits [112:102] are spare and travel through untouched.
  localparam int CSR_SUBECODE_LSB = 0;
  localparam int CSR_ECODE_LSB    = 9;
  localparam int CSR_EX           = 15;
  localparam int CSR_ERTN         = 16;
  localparam int CSR_WMASK_LSB    = 17;
  localparam int CSR_WVALUE_LSB   = 49;
  localparam int CSR_CSR_WE       = 81;
  localparam int CSR_RD_LSB       = 82;
  localparam int CSR_NUM_LSB      = 87;
  localparam int CSR_RD_WE        = 101;

  // Exception codes
  localparam logic [5:0] ECODE_ALE = 6'h09;

  // One-hot load type, ordered as it sits on the bus
  typedef struct packed {
    logic ld_b;
    logic ld_bu;
    logic ld_h;
    logic ld_hu;
    logic ld_w;
  } ld_type_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load alignment: picks the byte/halfword/word out of the raw
// SRAM word using the low address bits and extends it to 32 bits.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  addr,
  input  ld_type_t    ld_type,
  input  logic        sign_ext,
  input  logic [31:0] raw_word,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte and halfword; addr[0] is ignored for halfwords
  always_comb begin
    byte_sel = raw_word[7:0];
    case (addr)
      2'd0: byte_sel = raw_word[7:0];
      2'd1: byte_sel = raw_word[15:8];
      2'd2: byte_sel = raw_word[23:16];
      2'd3: byte_sel = raw_word[31:24];
      default: byte_sel = raw_word[7:0];
    endcase
    half_sel = addr[1] ? raw_word[31:16] : raw_word[15:0];
  end

  // Extend the selected piece according to the load type
  always_comb begin
    result = '0;
    if (ld_type.ld_b || ld_type.ld_bu) begin
      result = {{24{sign_ext & byte_sel[7]}}, byte_sel};
    end else if (ld_type.ld_h || ld_type.ld_hu) begin
      result = {{16{sign_ext & half_sel[15]}}, half_sel};
    end else if (ld_type.ld_w) begin
      result = raw_word;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the execute bus and CSR sideband,
// holds SRAM read data across write-back stalls, aligns loads and presents
// the forwarding view of the resident instruction.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         exe_to_mem_valid,
  input  logic [EXE_TO_MEM_BUS_WD-1:0] exe_to_mem_bus,
  input  logic [CSR_BUS_WD-1:0]        csr_in,
  input  logic [31:0]                  badv_in,
  output logic                         mem_allowin,
  input  logic [31:0]                  data_sram_rdata,
  input  logic                         wb_allowin,
  input  logic                         wb_flush,
  output logic                         mem_to_wb_valid,
  output logic [MEM_TO_WB_BUS_WD-1:0]  mem_to_wb_bus,
  output logic [CSR_BUS_WD-1:0]        csr_out,
  output logic [31:0]                  badv_out,
  output logic                         mem_ex_flag,
  output logic                         gr_we_mem,
  output logic [4:0]                   dest_mem,
  output logic [31:0]                  forward_data_mem
);

  logic                         mem_valid_q, mem_valid_d;
  logic [EXE_TO_MEM_BUS_WD-1:0] bus_q, bus_d;
  logic [CSR_BUS_WD-1:0]        csr_q, csr_d;
  logic [31:0]                  badv_q, badv_d;
  logic [31:0]                  rdata_buf_q, rdata_buf_d;
  logic                         buf_valid_q, buf_valid_d;

  logic        accept;
  ld_type_t    ld_type;
  logic        signed_opt;
  logic        lu12i_w;
  logic        load_op;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic        csr_rd_we;
  logic [4:0]  csr_rd;
  logic        csr_ex;
  logic        csr_ertn;
  logic        sign_ext;
  logic [31:0] ld_data;
  logic [31:0] aligned_load;
  logic [31:0] final_result;

  // Handshake: this stage always finishes in one cycle
  always_comb begin
    mem_allowin     = !mem_valid_q || wb_allowin;
    mem_to_wb_valid = mem_valid_q && !wb_flush;
    accept          = exe_to_mem_valid && mem_allowin;
  end

  // Next-state for valid, latched buses and the read-data buffer
  always_comb begin
    mem_valid_d = mem_valid_q;
    bus_d       = bus_q;
    csr_d       = csr_q;
    badv_d      = badv_q;
    rdata_buf_d = rdata_buf_q;
    buf_valid_d = buf_valid_q;

    if (wb_flush) begin
      mem_valid_d = 1'b0;
    end else if (mem_allowin) begin
      mem_valid_d = exe_to_mem_valid;
    end

    if (accept) begin
      bus_d  = exe_to_mem_bus;
      csr_d  = csr_in;
      badv_d = badv_in;
    end

    // SRAM data is only present on the first resident cycle; if write-back
    // stalls then, keep a copy. mem_allowin low implies a stalled resident.
    if (wb_flush || mem_allowin) begin
      buf_valid_d = 1'b0;
    end else if (!buf_valid_q) begin
      buf_valid_d = 1'b1;
      rdata_buf_d = data_sram_rdata;
    end
  end

  // Stage registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid_q <= 1'b0;
      bus_q       <= '0;
      csr_q       <= '0;
      badv_q      <= '0;
      rdata_buf_q <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      mem_valid_q <= mem_valid_d;
      bus_q       <= bus_d;
      csr_q       <= csr_d;
      badv_q      <= badv_d;
      rdata_buf_q <= rdata_buf_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  // Unpack the latched bus and sideband fields
  always_comb begin
    ld_type    = ld_type_t'(bus_q[BUS_LDTYPE_LSB +: 5]);
    signed_opt = bus_q[BUS_SIGNED_OPT];
    lu12i_w    = bus_q[BUS_LU12I_W];
    load_op    = bus_q[BUS_LOAD_OP];
    gr_we      = bus_q[BUS_GR_WE];
    dest       = bus_q[BUS_DEST_LSB +: 5];
    alu_result = bus_q[BUS_ALU_LSB +: 32];
    pc         = bus_q[BUS_PC_LSB +: 32];
    csr_rd_we  = csr_q[CSR_RD_WE];
    csr_rd     = csr_q[CSR_RD_LSB +: 5];
    csr_ex     = csr_q[CSR_EX];
    csr_ertn   = csr_q[CSR_ERTN];
  end

  // Signedness comes from the load type; a full word has nothing to extend,
  // so signed_option cannot alter ld_w results.
  always_comb begin
    sign_ext = ld_type.ld_b || ld_type.ld_h || (signed_opt && ld_type.ld_w);
    ld_data  = buf_valid_q ? rdata_buf_q : data_sram_rdata;
  end

  mem_stage_load_align u_load_align (
    .addr     (alu_result[1:0]),
    .ld_type  (ld_type),
    .sign_ext (sign_ext),
    .raw_word (ld_data),
    .result   (aligned_load)
  );

  // Result selection and outgoing buses; lu12i_w is never a load, its
  // upper-immediate value already sits in alu_result
  always_comb begin
    final_result     = (load_op && !lu12i_w) ? aligned_load : alu_result;
    mem_to_wb_bus    = {gr_we && !csr_ex, dest, final_result, pc};
    badv_out         = badv_q;
    csr_out          = csr_q;
    csr_out[CSR_RD_WE]  = csr_q[CSR_RD_WE]  && mem_valid_q;
    csr_out[CSR_CSR_WE] = csr_q[CSR_CSR_WE] && mem_valid_q;
    csr_out[CSR_ERTN]   = csr_ertn && mem_valid_q;
    csr_out[CSR_EX]     = csr_ex && mem_valid_q;
    mem_ex_flag      = mem_valid_q && (csr_ex || csr_ertn);
    gr_we_mem        = mem_valid_q && (gr_we || csr_rd_we);
    dest_mem         = mem_valid_q ? (csr_rd_we ? csr_rd : dest) : 5'd0;
    forward_data_mem = mem_valid_q ? final_result : 32'd0;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: load alignment, stall buffering, flush,
// exception sideband and asynchronous reset.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic         clk = 1'b0;
  logic         resetn;
  logic         exe_to_mem_valid;
  logic [77:0]  exe_to_mem_bus;
  logic [112:0] csr_in;
  logic [31:0]  badv_in;
  logic         mem_allowin;
  logic [31:0]  data_sram_rdata;
  logic         wb_allowin;
  logic         wb_flush;
  logic         mem_to_wb_valid;
  logic [69:0]  mem_to_wb_bus;
  logic [112:0] csr_out;
  logic [31:0]  badv_out;
  logic         mem_ex_flag;
  logic         gr_we_mem;
  logic [4:0]   dest_mem;
  logic [31:0]  forward_data_mem;

  int vecCount = 0;
  int errCount = 0;

  localparam logic [4:0] LD_B  = 5'b10000;
  localparam logic [4:0] LD_BU = 5'b01000;
  localparam logic [4:0] LD_H  = 5'b00100;
  localparam logic [4:0] LD_HU = 5'b00010;
  localparam logic [4:0] LD_W  = 5'b00001;
  localparam logic [4:0] NO_LD = 5'b00000;

  mem_stage dut (
    .clk              (clk),
    .resetn           (resetn),
    .exe_to_mem_valid (exe_to_mem_valid),
    .exe_to_mem_bus   (exe_to_mem_bus),
    .csr_in           (csr_in),
    .badv_in          (badv_in),
    .mem_allowin      (mem_allowin),
    .data_sram_rdata  (data_sram_rdata),
    .wb_allowin       (wb_allowin),
    .wb_flush         (wb_flush),
    .mem_to_wb_valid  (mem_to_wb_valid),
    .mem_to_wb_bus    (mem_to_wb_bus),
    .csr_out          (csr_out),
    .badv_out         (badv_out),
    .mem_ex_flag      (mem_ex_flag),
    .gr_we_mem        (gr_we_mem),
    .dest_mem         (dest_mem),
    .forward_data_mem (forward_data_mem)
  );

  // Free-running stage clock, 10 time units per cycle
  always #5 clk = ~clk;

  function automatic logic [77:0] makeBus(input logic [4:0] ldType, input logic signedOpt,
                                          input logic loadOp, input logic grWe,
                                          input logic [4:0] dest, input logic [31:0] alu,
                                          input logic [31:0] pc);
    return {ldType, signedOpt, 1'b0, loadOp, grWe, dest, alu, pc};
  endfunction

  function automatic logic [112:0] makeCsr(input logic rdWe, input logic [4:0] rd,
                                           input logic ertn, input logic ex,
                                           input logic [5:0] ecode);
    return {11'h0, rdWe, 14'h0, rd, 1'b0, 32'h0, 32'h0, ertn, ex, ecode, 9'h0};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    vecCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drain the stage, then present one instruction and its first-cycle SRAM data
  task automatic applyStimulus(input logic [77:0] bus, input logic [112:0] csr,
                               input logic [31:0] badv, input logic [31:0] rdata,
                               input logic wbAllow);
    exe_to_mem_valid = 1'b0;
    wb_allowin       = 1'b1;
    @(posedge clk); #1;
    exe_to_mem_valid = 1'b1;
    exe_to_mem_bus   = bus;
    csr_in           = csr;
    badv_in          = badv;
    wb_allowin       = wbAllow;
    @(posedge clk); #1;
    exe_to_mem_valid = 1'b0;
    data_sram_rdata  = rdata;
    #1;
  endtask

  task automatic runLoad(input string tag, input logic [4:0] ldType, input logic signedOpt,
                         input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [31:0] expected);
    applyStimulus(makeBus(ldType, signedOpt, 1'b1, 1'b1, 5'd4, addr, 32'h1c00_0100),
                  '0, 32'h0, rdata, 1'b1);
    checkOutput(tag, mem_to_wb_bus[63:32], expected);
    checkOutput({tag, "_fwd"}, forward_data_mem, expected);
  endtask

  initial begin
    resetn           = 1'b0;
    exe_to_mem_valid = 1'b0;
    exe_to_mem_bus   = '0;
    csr_in           = '0;
    badv_in          = '0;
    data_sram_rdata  = 32'h0;
    wb_allowin       = 1'b0;
    wb_flush         = 1'b0;

    #12;
    checkOutput("rst_allowin", mem_allowin, 1'b1);
    checkOutput("rst_valid", mem_to_wb_valid, 1'b0);
    checkOutput("rst_bus", mem_to_wb_bus, 70'h0);
    checkOutput("rst_csr", csr_out, 113'h0);
    checkOutput("rst_badv", badv_out, 32'h0);
    checkOutput("rst_fwd", {mem_ex_flag, gr_we_mem, dest_mem, forward_data_mem}, 39'h0);
    #1 resetn = 1'b1;

    // Byte/halfword/word alignment with no stall
    runLoad("ld_b_1003", LD_B, 1'b1, 32'h1003, 32'h80FF_1234, 32'hFFFF_FF80);
    checkOutput("ld_b_valid", mem_to_wb_valid, 1'b1);
    checkOutput("ld_b_grwe_dest", mem_to_wb_bus[69:64], {1'b1, 5'd4});
    checkOutput("ld_b_pc", mem_to_wb_bus[31:0], 32'h1c00_0100);
    checkOutput("ld_b_fwd_we", {gr_we_mem, dest_mem}, {1'b1, 5'd4});
    runLoad("ld_bu_1003", LD_BU, 1'b0, 32'h1003, 32'h80FF_1234, 32'h0000_0080);
    runLoad("ld_bu_1001", LD_BU, 1'b0, 32'h1001, 32'h80FF_1234, 32'h0000_0012);
    runLoad("ld_b_1002", LD_B, 1'b1, 32'h1002, 32'h80FF_1234, 32'hFFFF_FFFF);
    runLoad("ld_b_1000", LD_B, 1'b1, 32'h1000, 32'h80FF_1234, 32'h0000_0034);
    runLoad("ld_h_1002", LD_H, 1'b1, 32'h1002, 32'h8001_7FFF, 32'hFFFF_8001);
    runLoad("ld_h_1003", LD_H, 1'b1, 32'h1003, 32'h8001_7FFF, 32'hFFFF_8001);
    runLoad("ld_h_1000", LD_H, 1'b1, 32'h1000, 32'h8001_7FFF, 32'h0000_7FFF);
    runLoad("ld_hu_1002", LD_HU, 1'b0, 32'h1002, 32'h8001_7FFF, 32'h0000_8001);
    runLoad("ld_w_1000", LD_W, 1'b1, 32'h1000, 32'h8001_7FFF, 32'h8001_7FFF);

    // Non-load: result is the ALU value whatever the SRAM shows
    applyStimulus(makeBus(NO_LD, 1'b0, 1'b0, 1'b1, 5'd6, 32'h55AA_1234, 32'h1c00_0200),
                  '0, 32'h0, 32'hFFFF_FFFF, 1'b1);
    checkOutput("alu_result", mem_to_wb_bus[63:32], 32'h55AA_1234);

    // CSR read: forwarding uses the CSR destination
    applyStimulus(makeBus(NO_LD, 1'b0, 1'b0, 1'b0, 5'd3, 32'h0000_0042, 32'h1c00_0204),
                  makeCsr(1'b1, 5'd7, 1'b0, 1'b0, 6'h0), 32'h0, 32'h0, 1'b1);
    checkOutput("csr_rd_fwd", {gr_we_mem, dest_mem}, {1'b1, 5'd7});
    checkOutput("csr_rd_we_out", csr_out[101], 1'b1);

    // Stall: first-cycle data must survive later SRAM changes
    applyStimulus(makeBus(LD_W, 1'b1, 1'b1, 1'b1, 5'd8, 32'h2000, 32'h1c00_0300),
                  '0, 32'h0, 32'h1234_5678, 1'b0);
    checkOutput("stall_c0_data", mem_to_wb_bus[63:32], 32'h1234_5678);
    checkOutput("stall_c0_allowin", mem_allowin, 1'b0);
    for (int i = 1; i < 3; i++) begin
      @(posedge clk); #1;
      data_sram_rdata = 32'hDEAD_BEEF;
      #1;
      checkOutput($sformatf("stall_c%0d_data", i), mem_to_wb_bus[63:32], 32'h1234_5678);
      checkOutput($sformatf("stall_c%0d_allowin", i), mem_allowin, 1'b0);
      checkOutput($sformatf("stall_c%0d_valid", i), mem_to_wb_valid, 1'b1);
    end
    wb_allowin = 1'b1;
    #1;
    checkOutput("stall_release_data", forward_data_mem, 32'h1234_5678);
    checkOutput("stall_release_allowin", mem_allowin, 1'b1);

    // Exception sideband flows through with gr_we masked
    applyStimulus(makeBus(NO_LD, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1001, 32'h1c00_0400),
                  makeCsr(1'b0, 5'd0, 1'b0, 1'b1, ECODE_ALE), 32'h1001, 32'h0, 1'b1);
    checkOutput("ex_flag", csr_out[15], 1'b1);
    checkOutput("ex_ecode", csr_out[14:9], 6'h9);
    checkOutput("ex_badv", badv_out, 32'h1001);
    checkOutput("ex_mem_ex_flag", mem_ex_flag, 1'b1);
    checkOutput("ex_bus_grwe", mem_to_wb_bus[69], 1'b0);
    checkOutput("ex_valid", mem_to_wb_valid, 1'b1);

    // Flush with a simultaneous upstream instruction: both are dropped
    applyStimulus(makeBus(NO_LD, 1'b0, 1'b0, 1'b1, 5'd9, 32'h77, 32'h1c00_0500),
                  '0, 32'h0, 32'h0, 1'b1);
    exe_to_mem_valid = 1'b1;
    exe_to_mem_bus   = makeBus(NO_LD, 1'b0, 1'b0, 1'b1, 5'd10, 32'h88, 32'h1c00_0504);
    wb_flush         = 1'b1;
    #1;
    checkOutput("flush_comb_valid", mem_to_wb_valid, 1'b0);
    @(posedge clk); #1;
    wb_flush         = 1'b0;
    exe_to_mem_valid = 1'b0;
    #1;
    checkOutput("flush_valid", mem_to_wb_valid, 1'b0);
    checkOutput("flush_fwd", {gr_we_mem, dest_mem, forward_data_mem}, 38'h0);
    checkOutput("flush_allowin", mem_allowin, 1'b1);

    // Asynchronous reset in the middle of a buffered stall
    applyStimulus(makeBus(LD_W, 1'b1, 1'b1, 1'b1, 5'd11, 32'h3000, 32'h1c00_0600),
                  '0, 32'h0, 32'hCAFE_F00D, 1'b0);
    @(posedge clk); #1;
    data_sram_rdata = 32'h1111_1111;
    #1;
    checkOutput("rststall_buf", mem_to_wb_bus[63:32], 32'hCAFE_F00D);
    #1 resetn = 1'b0;
    #1;
    checkOutput("rststall_valid", mem_to_wb_valid, 1'b0);
    checkOutput("rststall_allowin", mem_allowin, 1'b1);
    checkOutput("rststall_fwd", {gr_we_mem, forward_data_mem}, 33'h0);
    checkOutput("rststall_bus", mem_to_wb_bus, 70'h0);
    #2 resetn = 1'b1;
    #1;
    checkOutput("rstrel_allowin", mem_allowin, 1'b1);
    runLoad("post_rst_ld_w", LD_W, 1'b1, 32'h4000, 32'h0BAD_F00D, 32'h0BAD_F00D);

    exe_to_mem_valid = 1'b0;
    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
